// File: rtl/dual_debounce.sv
// Two independent switch debouncers (channels A and B). Each channel synchronizes
// its raw input, runs a four-state accept/reject FSM and emits a registered level and rising tick.
module dual_debounce #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic a_raw,
    input  logic b_raw,
    output logic a_db,
    output logic b_db,
    output logic a_tick,
    output logic b_tick
);
    localparam int NUM_LANES = 2;

    logic [NUM_LANES-1:0] raw, db, tick;

    assign raw = {b_raw, a_raw};

    generate
        for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
            dd_channel #(.DB_CYCLES(DB_CYCLES)) u_ch (
                .clk   (clk),
                .reset (reset),
                .raw   (raw[g]),
                .db    (db[g]),
                .tick  (tick[g])
            );
        end
    endgenerate

    assign a_db   = db[0];
    assign b_db   = db[1];
    assign a_tick = tick[0];
    assign b_tick = tick[1];
endmodule

// One debounce channel: 2-flop synchronizer, ZERO/WAIT1/ONE/WAIT0 FSM, stability counter.
module dd_channel #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic db,
    output logic tick
);
    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        WAIT1 = 2'b01,
        ONE   = 2'b11,
        WAIT0 = 2'b10
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    sync_ff;
    logic          sync_x;
    logic          rise;

    assign sync_x = sync_ff[1];

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rise    = 1'b0;
        case (state)
            ZERO: begin
                if (sync_x) begin
                    state_n = WAIT1;
                    cnt_n   = '0;
                end
            end
            WAIT1: begin
                if (!sync_x) begin
                    state_n = ZERO;
                end else if (cnt == LAST) begin
                    state_n = ONE;
                    rise    = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ONE: begin
                if (!sync_x) begin
                    state_n = WAIT0;
                    cnt_n   = '0;
                end
            end
            WAIT0: begin
                if (sync_x) begin
                    state_n = ONE;
                end else if (cnt == LAST) begin
                    state_n = ZERO;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = ZERO;
                cnt_n   = '0;
            end
        endcase
    end

    // db gets its own flop so the output never glitches on a state-code change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_ff <= 2'b00;
            state   <= ZERO;
            cnt     <= '0;
            db      <= 1'b0;
            tick    <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[0], raw};
            state   <= state_n;
            cnt     <= cnt_n;
            db      <= (state_n == ONE) || (state_n == WAIT0);
            tick    <= rise;
        end
    end
endmodule

// File: tb/tb_dual_debounce.sv
// Self-checking bench for dual_debounce at DB_CYCLES=4: vector table plus scoreboarded
// hand sequences for release, glitch, bounce, simultaneous press and reset corners.
module tb_dual_debounce;
    logic clk = 1'b0;
    logic reset;
    logic a_raw, b_raw;
    logic a_db, b_db, a_tick, b_tick;

    dual_debounce #(.DB_CYCLES(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .a_raw  (a_raw),
        .b_raw  (b_raw),
        .a_db   (a_db),
        .b_db   (b_db),
        .a_tick (a_tick),
        .b_tick (b_tick)
    );

    always #5 clk = ~clk;

    // Expected output order: {a_db, b_db, a_tick, b_tick}
    typedef struct {
        logic       a;
        logic       b;
        logic [3:0] exp;
    } vec_t;

    typedef struct {
        logic [3:0] exp;
        string      nm;
    } sb_t;

    sb_t  sb_q[$];
    int   checks = 0;
    int   errors = 0;
    logic both_prev = 1'b0;
    int   both_rise = 0;

    task automatic compare(input logic [3:0] exp, input string nm);
        logic [3:0] act;
        act = {a_db, b_db, a_tick, b_tick};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b want %b (a_db b_db a_tick b_tick) t=%0t", nm, act, exp, $time);
        end
    endtask

    // Drive inputs, queue the expectation, advance one edge and check just after it.
    task automatic step(input logic a, input logic b, input logic [3:0] exp, input string nm);
        sb_t item;
        sb_t got;
        a_raw    = a;
        b_raw    = b;
        item.exp = exp;
        item.nm  = nm;
        sb_q.push_back(item);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        compare(got.exp, got.nm);
        if ((a_db & b_db) && !both_prev) both_rise++;
        both_prev = a_db & b_db;
    endtask

    vec_t press[9];

    initial begin
        for (int i = 0; i < 9; i++) begin
            press[i].a   = 1'b1;
            press[i].b   = 1'b0;
            press[i].exp = (i < 6) ? 4'b0000 : (i == 6) ? 4'b1010 : 4'b1000;
        end

        // Reset state
        reset = 1'b0;
        a_raw = 1'b0;
        b_raw = 1'b0;
        #12;
        compare(4'b0000, "reset_async");
        @(posedge clk);
        #1;
        compare(4'b0000, "reset_held");
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'b0000, "idle");

        // Clean press on A: db and tick at the 7th edge, tick gone one edge later
        for (int i = 0; i < 9; i++) step(press[i].a, press[i].b, press[i].exp, "clean_press");

        // Release: no tick, db falls at the 7th edge
        for (int i = 0; i < 7; i++)
            step(1'b0, 1'b0, (i < 6) ? 4'b1000 : 4'b0000, "release");

        // Press again, then a 3-cycle low glitch must not drop db
        for (int i = 0; i < 8; i++)
            step(1'b1, 1'b0, (i < 6) ? 4'b0000 : (i == 6) ? 4'b1010 : 4'b1000, "repress");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'b1000, "glitch_low");
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 4'b1000, "glitch_hold");
        for (int i = 0; i < 7; i++)
            step(1'b0, 1'b0, (i < 6) ? 4'b1000 : 4'b0000, "release2");

        // Bounce: 2 high / 1 low, five times, then low
        for (int r = 0; r < 5; r++) begin
            step(1'b1, 1'b0, 4'b0000, "bounce_hi");
            step(1'b1, 1'b0, 4'b0000, "bounce_hi");
            step(1'b0, 1'b0, 4'b0000, "bounce_lo");
        end
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 4'b0000, "bounce_settle");

        // Simultaneous press; downstream both-high condition must occur exactly once
        both_rise = 0;
        for (int i = 0; i < 9; i++)
            step(1'b1, 1'b1, (i < 6) ? 4'b0000 : (i == 6) ? 4'b1111 : 4'b1100, "simultaneous");
        checks++;
        if (both_rise != 1) begin
            errors++;
            $display("FAIL integration_both_once got %0d want 1", both_rise);
        end

        // Reset while in ONE: outputs clear at once, re-accept with full latency, no pulse on release
        #2;
        reset = 1'b0;
        a_raw = 1'b1;
        b_raw = 1'b0;
        #1;
        compare(4'b0000, "reset_in_one");
        reset = 1'b1;
        for (int i = 0; i < 8; i++)
            step(1'b1, 1'b0, (i < 6) ? 4'b0000 : (i == 6) ? 4'b1010 : 4'b1000, "after_reset_one");
        for (int i = 0; i < 7; i++)
            step(1'b0, 1'b0, (i < 6) ? 4'b1000 : 4'b0000, "release3");

        // Reset two cycles into WAIT1
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'b0000, "wait1_entry");
        #2;
        reset = 1'b0;
        #1;
        compare(4'b0000, "reset_in_wait1");
        @(posedge clk);
        #1;
        compare(4'b0000, "reset_in_wait1_held");
        reset = 1'b1;
        for (int i = 0; i < 8; i++)
            step(1'b1, 1'b0, (i < 6) ? 4'b0000 : (i == 6) ? 4'b1010 : 4'b1000, "after_reset_wait1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
